comm_ber_monitor: RTL

Loopback error monitor downstream of the comm datapath. It consumes each received 6-bit raw symbol together with the matching transmitted symbol, already FIFO-aligned, and compares them over a programmable window. It accumulates symbol, symbol-error and bit-error counts for link bring-up and for sweeping the AD delay settings.

---
 rtl/comm_pkg.sv | 15 +
 rtl/comm_ber_monitor_if.sv | 31 +++
 rtl/comm_ber_monitor_sat_counter.sv | 26 ++
 rtl/comm_ber_monitor.sv | 106 ++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the comm loopback BER monitor: FSM encoding,
// default raw-symbol width and histogram bin count.
package comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SYM_W_DEF = 6;
    localparam int HIST_BINS = 6;

endpackage

// File: rtl/comm_ber_monitor_if.sv
// Control, symbol-pair and result bundle of comm_ber_monitor. The monitor
// sits on the slave side; whoever drives the measurement is the master.
interface comm_ber_monitor_if
    import comm_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SYM_W = SYM_W_DEF
);
    logic                       start;
    logic                       stop;
    logic [CNT_W-1:0]           window_len;
    logic                       valid_raw_recv;
    logic [SYM_W-1:0]           raw_send_d;
    logic [SYM_W-1:0]           raw_recv;
    logic                       busy;
    logic                       done;
    logic [CNT_W-1:0]           sym_cnt;
    logic [CNT_W-1:0]           sym_err_cnt;
    logic [CNT_W-1:0]           bit_err_cnt;
    logic [HIST_BINS*CNT_W-1:0] err_hist;

    modport master (
        output start, stop, window_len, valid_raw_recv, raw_send_d, raw_recv,
        input  busy, done, sym_cnt, sym_err_cnt, bit_err_cnt, err_hist
    );

    modport slave (
        input  start, stop, window_len, valid_raw_recv, raw_send_d, raw_recv,
        output busy, done, sym_cnt, sym_err_cnt, bit_err_cnt, err_hist
    );
endinterface

// File: rtl/comm_ber_monitor_sat_counter.sv
// Saturating accumulator: adds amt_i when en_i, sticks at all-ones instead
// of wrapping. clr_i wins over en_i.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] amt_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W:0]   sum;

    assign sum   = {1'b0, cnt_q} + {1'b0, amt_i};
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= sum[W] ? '1 : sum[W-1:0];
        end
    end
endmodule

// File: rtl/comm_ber_monitor.sv
// Loopback BER monitor: compares aligned tx/rx raw symbols over a window and
// accumulates counts. Define COMM_BER_HIST_EN to build the error-weight histogram.
module comm_ber_monitor
    import comm_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SYM_W = SYM_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    comm_ber_monitor_if.slave bus
);
    localparam int WGT_W = $clog2(SYM_W + 1);

    state_e           state_q;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] win_q, acc_q, acc_d;
    logic             accept, last;
    logic             vld_p1;
    logic [SYM_W-1:0] err_p1;
    logic [WGT_W-1:0] weight_p1;

    // A pair presented with start or stop is never counted.
    assign accept = (state_q == ST_RUN) && bus.valid_raw_recv && !bus.start && !bus.stop;
    assign acc_d  = acc_q + CNT_W'(1);
    assign last   = (win_q != '0) && (acc_d == win_q);

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '0;
            acc_q   <= '0;
            vld_p1  <= 1'b0;
        end else if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            win_q   <= bus.window_len;
            acc_q   <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= accept;
            case (state_q)
                ST_RUN: begin
                    if (bus.stop) begin
                        state_q <= ST_DRAIN;
                    end else if (accept) begin
                        if (win_q != '0) acc_q <= acc_d;
                        if (last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // stage 1: capture the error pattern of the accepted pair
    always_ff @(posedge CLK) begin
        err_p1 <= bus.raw_send_d ^ bus.raw_recv;
    end

    always_comb begin
        weight_p1 = '0;
        for (int i = 0; i < SYM_W; i++) begin
            weight_p1 = weight_p1 + WGT_W'(err_p1[i]);
        end
    end

    // stage 2: saturating result counters
    sat_counter #(.W(CNT_W)) u_sym_cnt (
        .clk_i(CLK), .rst_ni(RST), .clr_i(bus.start), .en_i(vld_p1),
        .amt_i(CNT_W'(1)), .cnt_o(bus.sym_cnt)
    );

    sat_counter #(.W(CNT_W)) u_sym_err_cnt (
        .clk_i(CLK), .rst_ni(RST), .clr_i(bus.start), .en_i(vld_p1 && (weight_p1 != '0)),
        .amt_i(CNT_W'(1)), .cnt_o(bus.sym_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bit_err_cnt (
        .clk_i(CLK), .rst_ni(RST), .clr_i(bus.start), .en_i(vld_p1),
        .amt_i(CNT_W'(weight_p1)), .cnt_o(bus.bit_err_cnt)
    );

`ifdef COMM_BER_HIST_EN
    for (genvar w = 1; w <= HIST_BINS; w++) begin : g_hist
        sat_counter #(.W(CNT_W)) u_bin (
            .clk_i(CLK), .rst_ni(RST), .clr_i(bus.start),
            .en_i(vld_p1 && (weight_p1 == WGT_W'(w))),
            .amt_i(CNT_W'(1)), .cnt_o(bus.err_hist[(w-1)*CNT_W +: CNT_W])
        );
    end
`else
    assign bus.err_hist = '0;
`endif
endmodule
